serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 16: operand and difference width in bits.
REQ-002 Parameter CHUNK, default 4: bits processed per clock; WIDTH SHALL be an integer multiple of CHUNK, with NCHUNK = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start_valid  input  1  operands and inborrow are valid this cycle.
REQ-006 start_ready  output  1  block accepts a new operation.
REQ-007 minuend  input  WIDTH  value from which the subtraction is done.
REQ-008 subtrahend  input  WIDTH  value subtracted.
REQ-009 inborrow  input  1  borrow into the least significant chunk.
REQ-010 diff  output  WIDTH  registered result of minuend - subtrahend - inborrow.
REQ-011 outborrow  output  1  registered borrow out of the most significant chunk; 1 means a borrow was required.
REQ-012 result_valid  output  1  diff and outborrow are valid.
REQ-013 result_ready  input  1  consumer accepts the result.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN and DONE; start_ready SHALL be 1 only in IDLE, and result_valid SHALL be 1 only in DONE.
REQ-015 IDLE: on start_valid=1, the block SHALL capture minuend, subtrahend and inborrow, clear the chunk counter and enter RUN.
REQ-016 RUN: in each cycle the block SHALL compute one CHUNK slice, starting with the LSB slice, as slice diff = a - b - borrow, and register the slice's borrow out as the next borrow.
REQ-017 RUN SHALL last exactly NCHUNK cycles; after the last slice the block SHALL latch outborrow and enter DONE, so result_valid rises NCHUNK+1 cycles after the accepting edge.
REQ-018 When WIDTH equals CHUNK, RUN SHALL last one cycle; no special-casing SHALL be required.
REQ-019 DONE: diff and outborrow SHALL be held stable while result_ready=0; on result_ready=1 the block SHALL return to IDLE on the next edge.
REQ-020 start_valid SHALL be ignored in RUN and DONE; operand inputs SHALL be don't-care outside the accepting cycle.
REQ-021 Arithmetic SHALL be modulo 2^WIDTH; wrap-around SHALL be flagged only by outborrow.
REQ-022 diff SHALL be updated slice-by-slice during RUN, but it SHALL be qualified only by result_valid.

Reset
REQ-023 While rst_n=0, the block SHALL have state IDLE, diff=0, outborrow=0, result_valid=0, start_ready=1, counter=0 and internal borrow=0.
REQ-024 Reset asserted mid-RUN or in DONE SHALL abort the operation immediately, with no result delivered.

Configuration
REQ-025 Macro SERIAL_SUBTRACTOR_SAT_EN: when defined and the final outborrow=1, diff SHALL be forced to 0 on entry to DONE, and outborrow SHALL still report 1.
REQ-026 Without SERIAL_SUBTRACTOR_SAT_EN, diff SHALL be the wrapped modulo result.

Structure
REQ-027 A shared package sub_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default WIDTH/CHUNK constants.
REQ-028 The sub-module subtractor_chunk SHALL be a combinational CHUNK-bit ripple-borrow subtractor using per-bit logic: d = a^b^bin, bout = (~a&b) | (~(a^b)&bin).
REQ-029 serial_subtractor SHALL instantiate exactly one subtractor_chunk and time-multiplex it across slices.

Verification (WIDTH=16, CHUNK=4)
REQ-030 0x1234 - 0x0034, inborrow=0 -> diff=0x1200, outborrow=0, result_valid 5 cycles after acceptance.
REQ-031 0x0000 - 0x0001 -> diff=0xFFFF, outborrow=1; with SERIAL_SUBTRACTOR_SAT_EN -> diff=0x0000, outborrow=1.
REQ-032 0x8000 - 0x0000, inborrow=1 -> diff=0x7FFF, outborrow=0, with the borrow rippling through all four slices.
REQ-033 Hold result_ready=0 for 5 cycles in DONE and pulse start_valid -> diff and outborrow unchanged, start_ready=0, pulse ignored; result_ready=1 -> IDLE next cycle.
REQ-034 Assert rst_n=0 during the 2nd RUN cycle -> all outputs at reset values, start_ready=1 after release, and the next operation completes correctly.
REQ-035 Back-to-back operations with result_ready tied to 1 -> one IDLE cycle between results, and each result correct against a reference model over 1000 random operand/inborrow triples.

Source files
------------

// File: rtl/sub_pkg.sv
// sub_pkg: shared FSM state type and default operand geometry for serial_subtractor.
package sub_pkg;
    localparam int WIDTH_DEF = 16;
    localparam int CHUNK_DEF = 4;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/subtractor_chunk.sv
// subtractor_chunk: combinational CHUNK-bit ripple-borrow subtractor, d = a - b - bin.
module subtractor_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);
    logic br;
    always_comb begin
        br = bin;
        d = '0;
        for (int i = 0; i < CHUNK; i++) begin
            d[i] = a[i] ^ b[i] ^ br;
            br = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
        end
        bout = br;
    end
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: CHUNK-bit-per-cycle serial subtractor; SERIAL_SUBTRACTOR_SAT_EN saturates diff to 0 on borrow.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CHUNK = CHUNK_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    input  logic             inborrow,
    output logic [WIDTH-1:0] diff,
    output logic             outborrow,
    output logic             result_valid,
    input  logic             result_ready
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    state_e state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic borrow_q, borrow_d, outborrow_q, outborrow_d;
    logic [CHUNK-1:0] slice_d;
    logic slice_bout;
    // operands shift right so the active slice is always the low CHUNK bits
    subtractor_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a(a_q[CHUNK-1:0]),
        .b(b_q[CHUNK-1:0]),
        .bin(borrow_q),
        .d(slice_d),
        .bout(slice_bout)
    );
    always_comb begin
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        diff_d = diff_q;
        cnt_d = cnt_q;
        borrow_d = borrow_q;
        outborrow_d = outborrow_q;
        case (state_q)
            IDLE: if (start_valid) begin
                a_d = minuend;
                b_d = subtrahend;
                borrow_d = inborrow;
                cnt_d = '0;
                state_d = RUN;
            end
            RUN: begin
                a_d = a_q >> CHUNK;
                b_d = b_q >> CHUNK;
                diff_d[cnt_q*CHUNK +: CHUNK] = slice_d;
                borrow_d = slice_bout;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NCHUNK - 1)) begin
                    outborrow_d = slice_bout;
                    state_d = DONE;
`ifdef SERIAL_SUBTRACTOR_SAT_EN
                    if (slice_bout) diff_d = '0;
`endif
                end
            end
            DONE: if (result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            diff_q <= '0;
            cnt_q <= '0;
            borrow_q <= 1'b0;
            outborrow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            diff_q <= diff_d;
            cnt_q <= cnt_d;
            borrow_q <= borrow_d;
            outborrow_q <= outborrow_d;
        end
    end
    assign start_ready = state_q == IDLE;
    assign result_valid = state_q == DONE;
    assign diff = diff_q;
    assign outborrow = outborrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor at WIDTH=16, CHUNK=4.
module tb_serial_subtractor;
    logic clk, rst_n, start_valid, start_ready, inborrow, outborrow, result_valid, result_ready;
    logic [15:0] minuend, subtrahend, diff;
    int total = 0, bad = 0, cyc = 0, last_res = -1;
    logic b2b = 0, vprev = 0, rprev = 0, pbor = 0;
    logic [15:0] pdiff = '0;
    typedef struct { logic [15:0] d; logic b; int acc; } exp_t;
    exp_t sb[$];
    serial_subtractor #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .minuend(minuend), .subtrahend(subtrahend), .inborrow(inborrow),
        .diff(diff), .outborrow(outborrow), .result_valid(result_valid), .result_ready(result_ready)
    );
    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    function automatic logic [16:0] model(input logic [15:0] m, s, input logic bi);
        logic [16:0] r;
        r = {1'b0, m} - {1'b0, s} - 17'(bi);
`ifdef SERIAL_SUBTRACTOR_SAT_EN
        if (r[16]) r[15:0] = '0;
`endif
        return r;
    endfunction
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            vprev = 0;
            rprev = 0;
        end else begin
            if (result_valid) begin
                chk("ready_in_done", start_ready, 0);
                if (!vprev) begin
                    if (sb.size() == 0) chk("unexpected_result", sb.size(), 1);
                    else chk("latency", cyc - sb[0].acc, 5);
                    if (b2b && last_res >= 0) chk("b2b_gap", cyc - last_res, 6);
                    last_res = cyc;
                end else if (!rprev) begin
                    chk("hold_diff", diff, pdiff);
                    chk("hold_borrow", outborrow, pbor);
                end
                if (result_ready && sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("diff", diff, e.d);
                    chk("outborrow", outborrow, e.b);
                end
            end
            vprev = result_valid;
            rprev = result_ready;
            pdiff = diff;
            pbor = outborrow;
        end
    end
    task automatic op(input logic [15:0] m, s, input logic bi, input logic [15:0] ed, input logic eb);
        int n = 0;
        @(negedge clk);
        while (!start_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!start_ready) chk("start_timeout", start_ready, 1);
        else begin
            minuend = m;
            subtrahend = s;
            inborrow = bi;
            start_valid = 1;
            sb.push_back('{ed, eb, cyc});
            @(posedge clk);
            #1 start_valid = 0;
        end
    endtask
    task automatic drain;
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask
    initial begin
        logic [16:0] r;
        logic [15:0] m, s;
        logic bi;
        int n;
        rst_n = 0; start_valid = 0; result_ready = 1;
        minuend = '0; subtrahend = '0; inborrow = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_diff", diff, 0);
        chk("rst_borrow", outborrow, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_ready", start_ready, 1);
        rst_n = 1;
        op(16'h1234, 16'h0034, 0, 16'h1200, 0);
`ifdef SERIAL_SUBTRACTOR_SAT_EN
        op(16'h0000, 16'h0001, 0, 16'h0000, 1);
        op(16'hFFFF, 16'hFFFF, 1, 16'h0000, 1);
`else
        op(16'h0000, 16'h0001, 0, 16'hFFFF, 1);
        op(16'hFFFF, 16'hFFFF, 1, 16'hFFFF, 1);
`endif
        op(16'h8000, 16'h0000, 1, 16'h7FFF, 0);
        op(16'h0005, 16'h0003, 1, 16'h0001, 0);
        op(16'h1000, 16'h0001, 0, 16'h0FFF, 0);
        drain();
        @(posedge clk);
        #1 result_ready = 0;
        op(16'h5678, 16'h1111, 0, 16'h4567, 0);
        n = 0;
        while (!result_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        chk("hold_reach_done", result_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 start_valid = i[0];
            minuend = 16'hAAAA;
            subtrahend = 16'h5555;
        end
        @(posedge clk);
        #1 start_valid = 0;
        result_ready = 1;
        @(posedge clk);
        #1;
        chk("idle_after_done", start_ready, 1);
        chk("valid_after_done", result_valid, 0);
        chk("hold_popped", sb.size(), 0);
        op(16'h1234, 16'h0034, 0, 16'h1200, 0);
        @(posedge clk);
        #1 rst_n = 0;
        sb.delete();
        #1;
        chk("abort_diff", diff, 0);
        chk("abort_borrow", outborrow, 0);
        chk("abort_valid", result_valid, 0);
        chk("abort_ready", start_ready, 1);
        @(posedge clk);
        #1 rst_n = 1;
        chk("ready_after_rst", start_ready, 1);
        op(16'hABCD, 16'h1234, 0, 16'h9999, 0);
        drain();
        last_res = -1;
        b2b = 1;
        for (int i = 0; i < 1000; i++) begin
            m = 16'($urandom);
            s = 16'($urandom);
            bi = 1'($urandom_range(0, 1));
            r = model(m, s, bi);
            op(m, s, bi, r[15:0], r[16]);
        end
        drain();
        b2b = 0;
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
